// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the rPLL supervisor / dynamic phase controller.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PRST,
    WLOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  typedef logic [3:0] phase_code_t;

  // DUTYDA tracks PSDA so the high time stays constant; wraps mod 16.
  function automatic phase_code_t duty_for(phase_code_t psda, phase_code_t offset);
    return psda + offset;
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_sync2.sv
// Two-flop synchronizer for the asynchronous PLL lock indication.
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// rPLL supervisor: reset/lock sequencing with timeout and retry, downstream reset
// release after stable lock, and PSDA/DUTYDA phase stepping while running.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 4096,  // must be >= 2
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3,
  parameter phase_code_t PSDA_INIT     = 4'd0,
  parameter phase_code_t DUTY_OFFSET   = 4'd8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       phase_inc,
  input  logic       phase_dec,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  output logic       sys_rst,
  output logic       locked,
  output logic       busy,
  output logic       fail,
  output logic [1:0] retry_cnt
);

  localparam int unsigned MaxA   = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int unsigned CntMax = (MaxA > SETTLE_CYCLES) ? MaxA : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  // The WLOCK cycle that saw lock_s=1 is the first of the stable run.
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 2);
  localparam logic [CntW-1:0] SettleLast  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [1:0]      MaxRetry    = 2'(MAX_RETRY);

  logic            lock_s;
  state_t          state;
  logic [CntW-1:0] cnt;
  logic [1:0]      retry_next;

  sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign retry_next = retry_cnt + 2'd1;

  // Sequencer FSM; every output is updated alongside the transition that implies it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PRST;
      cnt       <= '0;
      pll_reset <= 1'b1;
      psda      <= PSDA_INIT;
      dutyda    <= duty_for(PSDA_INIT, DUTY_OFFSET);
      sys_rst   <= 1'b1;
      locked    <= 1'b0;
      busy      <= 1'b1;
      fail      <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      case (state)
        PRST: begin
          if (relock_req) begin
            cnt <= '0;
          end else if (cnt == RstLast) begin
            state     <= WLOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WLOCK: begin
          if (relock_req) begin
            state     <= PRST;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TimeoutLast) begin
            cnt       <= '0;
            pll_reset <= 1'b1;
            retry_cnt <= retry_next;
            if (retry_next == MaxRetry) begin
              state <= FAIL;
              fail  <= 1'b1;
            end else begin
              state <= PRST;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STABLE: begin
          if (relock_req) begin
            state     <= PRST;
            cnt       <= '0;
            pll_reset <= 1'b1;
          end else if (!lock_s) begin
            // A glitch restarts the wait but is not a failed attempt.
            state <= WLOCK;
            cnt   <= '0;
          end else if (cnt == StableLast) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst   <= 1'b0;
            locked    <= 1'b1;
            busy      <= 1'b0;
            retry_cnt <= 2'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RUN: begin
          if (!lock_s || relock_req) begin
            // psda is deliberately kept so the relocked PLL resumes the same phase.
            state     <= PRST;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            busy      <= 1'b1;
          end else if (busy) begin
            if (cnt == SettleLast) begin
              busy <= 1'b0;
              cnt  <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (phase_inc && !phase_dec) begin
            psda   <= psda + 4'd1;
            dutyda <= duty_for(psda + 4'd1, DUTY_OFFSET);
            busy   <= 1'b1;
            cnt    <= '0;
          end else if (phase_dec && !phase_inc) begin
            psda   <= psda - 4'd1;
            dutyda <= duty_for(psda - 4'd1, DUTY_OFFSET);
            busy   <= 1'b1;
            cnt    <= '0;
          end
        end

        FAIL: begin
          if (relock_req) begin
            state     <= PRST;
            cnt       <= '0;
            fail      <= 1'b0;
            retry_cnt <= 2'd0;
          end
        end

        default: begin
          state     <= PRST;
          cnt       <= '0;
          pll_reset <= 1'b1;
          sys_rst   <= 1'b1;
          locked    <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed sequencing checks plus randomized phase stepping against a timing model.
module tb_pll_phase_ctrl;

  localparam int unsigned RstC    = 4;
  localparam int unsigned TimeOut = 32;
  localparam int unsigned StableC = 8;
  localparam int unsigned SettleC = 6;
  localparam int unsigned MaxR    = 3;
  localparam int unsigned Offset  = 8;

  logic       clk = 1'b0;
  logic       reset, pll_lock, phase_inc, phase_dec, relock_req;
  logic       pll_reset, sys_rst, locked, busy, fail;
  logic [3:0] psda, dutyda;
  logic [1:0] retry_cnt;

  int vectors = 0;
  int miscompares = 0;
  int psda_m = 0;     // expected phase code
  int busy_left = 0;  // expected remaining settle cycles

  pll_phase_ctrl #(
    .RST_CYCLES    (RstC),
    .LOCK_TIMEOUT  (TimeOut),
    .STABLE_CYCLES (StableC),
    .SETTLE_CYCLES (SettleC),
    .MAX_RETRY     (MaxR),
    .PSDA_INIT     (4'd0),
    .DUTY_OFFSET   (4'(Offset))
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .phase_inc  (phase_inc),
    .phase_dec  (phase_dec),
    .relock_req (relock_req),
    .pll_reset  (pll_reset),
    .psda       (psda),
    .dutyda     (dutyda),
    .sys_rst    (sys_rst),
    .locked     (locked),
    .busy       (busy),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One RUN cycle with an optional request, checked against the phase model.
  task automatic step(input logic inc, input logic dec);
    phase_inc = inc;
    phase_dec = dec;
    tick();
    phase_inc = 1'b0;
    phase_dec = 1'b0;
    if (busy_left > 0) busy_left--;
    else if (inc != dec) begin
      psda_m    = inc ? (psda_m + 1) % 16 : (psda_m + 15) % 16;
      busy_left = SettleC;
    end
    chk("step_psda", 8'(psda), 8'(psda_m));
    chk("step_dutyda", 8'(dutyda), 8'((psda_m + Offset) % 16));
    chk("step_busy", 8'(busy), 8'(busy_left > 0));
    chk("step_locked", 8'(locked), 8'd1);
  endtask

  task automatic wait_locked(input string tag);
    int n = 0;
    while (locked !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 8'(locked), 8'd1);
  endtask

  initial begin
    int r;
    int n;
    int keep;
    reset = 1'b1; pll_lock = 1'b0; phase_inc = 1'b0; phase_dec = 1'b0; relock_req = 1'b0;
    tick(); tick();
    chk("rst_pll_reset", 8'(pll_reset), 8'd1);
    chk("rst_psda", 8'(psda), 8'd0);
    chk("rst_dutyda", 8'(dutyda), 8'd8);
    chk("rst_sys_rst", 8'(sys_rst), 8'd1);
    chk("rst_locked", 8'(locked), 8'd0);
    chk("rst_busy", 8'(busy), 8'd1);
    chk("rst_fail", 8'(fail), 8'd0);
    chk("rst_retry", 8'(retry_cnt), 8'd0);
    reset = 1'b0;

    // Power-up: reset pulse length, then lock -> sys_rst release after sync + stable window.
    repeat (RstC - 1) tick();
    chk("prst_hold", 8'(pll_reset), 8'd1);
    tick();
    chk("prst_release", 8'(pll_reset), 8'd0);
    repeat (10) tick();
    pll_lock = 1'b1;
    repeat (2 + StableC - 1) tick();
    chk("pwr_sys_rst_early", 8'(sys_rst), 8'd1);
    tick();
    chk("pwr_sys_rst", 8'(sys_rst), 8'd0);
    chk("pwr_locked", 8'(locked), 8'd1);
    chk("pwr_busy", 8'(busy), 8'd0);
    chk("pwr_psda", 8'(psda), 8'd0);
    chk("pwr_dutyda", 8'(dutyda), 8'd8);

    // Phase stepping: simultaneous no-op, wrap both ways, request dropped while settling.
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("dec_wrap_psda", 8'(psda), 8'd15);
    chk("dec_wrap_duty", 8'(dutyda), 8'd7);
    repeat (SettleC) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("inc_wrap_psda", 8'(psda), 8'd0);
    chk("inc_wrap_duty", 8'(dutyda), 8'd8);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("busy_drop_psda", 8'(psda), 8'd0);
    repeat (SettleC) step(1'b0, 1'b0);
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 7));
      step(r == 0 || r == 2, r == 1 || r == 2);
    end

    // Lock loss while settling: supervisor drops out, phase kept across relock.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    keep = psda_m;
    pll_lock = 1'b0;
    repeat (3) tick();
    chk("loss_sys_rst", 8'(sys_rst), 8'd1);
    chk("loss_locked", 8'(locked), 8'd0);
    chk("loss_pll_reset", 8'(pll_reset), 8'd1);
    chk("loss_psda", 8'(psda), 8'(keep));
    pll_lock = 1'b1;
    wait_locked("relock_run");
    chk("relock_psda", 8'(psda), 8'(keep));
    busy_left = 0;

    // Relock request, then a one-cycle lock glitch inside STABLE.
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("req_pll_reset", 8'(pll_reset), 8'd1);
    chk("req_sys_rst", 8'(sys_rst), 8'd1);
    n = 0;
    while (pll_reset !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("req_wlock", 8'(pll_reset), 8'd0);
    tick(); tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (2 + StableC - 1) tick();
    chk("glitch_sys_rst_held", 8'(sys_rst), 8'd1);
    chk("glitch_retry", 8'(retry_cnt), 8'd0);
    tick();
    chk("glitch_sys_rst", 8'(sys_rst), 8'd0);
    chk("glitch_locked", 8'(locked), 8'd1);

    // Lock never returns: timed retries, then sticky fail until relock_req.
    pll_lock = 1'b0;
    repeat (3) tick();
    chk("to_prst", 8'(pll_reset), 8'd1);
    for (int a = 1; a <= int'(MaxR); a++) begin
      repeat (RstC + TimeOut - 1) tick();
      chk("to_retry_before", 8'(retry_cnt), 8'(a - 1));
      chk("to_fail_before", 8'(fail), 8'd0);
      tick();
      chk("to_retry_after", 8'(retry_cnt), 8'(a));
      chk("to_pll_reset", 8'(pll_reset), 8'd1);
    end
    chk("fail_set", 8'(fail), 8'd1);
    chk("fail_sys_rst", 8'(sys_rst), 8'd1);
    chk("fail_busy", 8'(busy), 8'd1);
    pll_lock = 1'b1;
    repeat (20) tick();
    chk("fail_sticky", 8'(fail), 8'd1);
    chk("fail_pll_reset", 8'(pll_reset), 8'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    chk("fail_clear", 8'(fail), 8'd0);
    chk("fail_retry_clear", 8'(retry_cnt), 8'd0);
    wait_locked("fail_relock_run");
    chk("fail_relock_psda", 8'(psda), 8'(keep));

    // Asynchronous reset mid-cycle restores reset values without a clock edge.
    step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_psda", 8'(psda), 8'd0);
    chk("arst_dutyda", 8'(dutyda), 8'd8);
    chk("arst_pll_reset", 8'(pll_reset), 8'd1);
    chk("arst_sys_rst", 8'(sys_rst), 8'd1);
    chk("arst_locked", 8'(locked), 8'd0);
    chk("arst_busy", 8'(busy), 8'd1);
    tick();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
